// File: rtl/axi_addr_arbiter.sv
// axi_addr_arbiter: round-robin arbiter sharing one AXI address channel (AW or AR)
//
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   req_valid      per-requester valid                   [NUM_MASTER]
//   req_ready      per-requester ready (one-hot or zero)  [NUM_MASTER]
//   req_id         packed requester IDs                   [NUM_MASTER*ID_WIDTH]
//   req_qos        packed requester QoS                   [NUM_MASTER*4]
//   req_payload    packed address-channel payloads        [NUM_MASTER*PAYLOAD_WIDTH]
//   grant_valid    valid toward downstream
//   grant_ready    downstream ready
//   grant_id       {winner index, winner ID}              [IDX_WIDTH+ID_WIDTH]
//   grant_payload  winner payload                         [PAYLOAD_WIDTH]
//   grant_qos      winner QoS                             [4]
//   grant_idx      winner index                           [IDX_WIDTH]
//
// Build option: define AXI_ARB_QOS_EN to arbitrate on highest QoS first, with
// round-robin among equal-QoS requesters. Without it selection is pure round-robin.
module axi_addr_arbiter #(
   parameter  int NUM_MASTER    = 4,
   parameter  int ID_WIDTH      = 4,
   parameter  int PAYLOAD_WIDTH = 64,
   localparam int IDX_WIDTH     = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic [NUM_MASTER-1:0]               req_valid,
   output logic [NUM_MASTER-1:0]               req_ready,
   input  logic [NUM_MASTER*ID_WIDTH-1:0]      req_id,
   input  logic [NUM_MASTER*4-1:0]             req_qos,
   input  logic [NUM_MASTER*PAYLOAD_WIDTH-1:0] req_payload,
   output logic                                grant_valid,
   input  logic                                grant_ready,
   output logic [IDX_WIDTH+ID_WIDTH-1:0]       grant_id,
   output logic [PAYLOAD_WIDTH-1:0]            grant_payload,
   output logic [3:0]                          grant_qos,
   output logic [IDX_WIDTH-1:0]                grant_idx
);
   typedef enum logic {IDLE, LOCKED} state_t;

   state_t               r_state, w_state_nxt;
   logic [IDX_WIDTH-1:0] r_rr_ptr, r_lock_idx, w_rr_nxt, w_lock_nxt, w_arb, w_winner;
   logic                 w_any, w_gv;

   // Position k steps after base in round-robin order; base < NUM_MASTER so one subtraction wraps.
   function automatic int rr_idx(input int base, input int k);
      int s;
      s = base + k;
      return (s >= NUM_MASTER) ? s - NUM_MASTER : s;
   endfunction

   function automatic logic [IDX_WIDTH-1:0] next_ptr(input logic [IDX_WIDTH-1:0] w);
      return (w == IDX_WIDTH'(NUM_MASTER - 1)) ? '0 : w + 1'b1;
   endfunction

   // Scan from farthest to nearest so the candidate closest to rr_ptr overwrites the rest.
`ifdef AXI_ARB_QOS_EN
   logic [3:0] w_best;
   always_comb begin
      w_arb  = '0;
      w_any  = 1'b0;
      w_best = '0;
      for (int k = NUM_MASTER - 1; k >= 0; k--) begin
         if (req_valid[rr_idx(int'(r_rr_ptr), k)] &&
             (!w_any || req_qos[rr_idx(int'(r_rr_ptr), k)*4 +: 4] >= w_best)) begin
            w_arb  = IDX_WIDTH'(rr_idx(int'(r_rr_ptr), k));
            w_best = req_qos[rr_idx(int'(r_rr_ptr), k)*4 +: 4];
            w_any  = 1'b1;
         end
      end
   end
`else
   always_comb begin
      w_arb = '0;
      w_any = |req_valid;
      for (int k = NUM_MASTER - 1; k >= 0; k--)
         if (req_valid[rr_idx(int'(r_rr_ptr), k)]) w_arb = IDX_WIDTH'(rr_idx(int'(r_rr_ptr), k));
   end
`endif

   // The locked requester owns the channel until it handshakes, even if it drops valid.
   // rstn gates valid so nothing is offered while the arbiter is held in reset.
   assign w_winner = (r_state == LOCKED) ? r_lock_idx : w_arb;
   assign w_gv     = rstn && ((r_state == LOCKED) ? req_valid[r_lock_idx] : w_any);

   assign grant_valid   = w_gv;
   assign grant_idx     = w_winner;
   assign grant_id      = {w_winner, req_id[int'(w_winner)*ID_WIDTH +: ID_WIDTH]};
   assign grant_payload = req_payload[int'(w_winner)*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
   assign grant_qos     = req_qos[int'(w_winner)*4 +: 4];

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_MASTER; i++)
         req_ready[i] = grant_ready && w_gv && (w_winner == IDX_WIDTH'(i));
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rr_nxt    = r_rr_ptr;
      w_lock_nxt  = r_lock_idx;
      if (w_gv && grant_ready) begin
         w_rr_nxt    = next_ptr(w_winner);
         w_state_nxt = IDLE;
      end else if (w_gv && r_state == IDLE) begin
         w_lock_nxt  = w_winner;
         w_state_nxt = LOCKED;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= IDLE;
         r_rr_ptr   <= '0;
         r_lock_idx <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rr_ptr   <= w_rr_nxt;
         r_lock_idx <= w_lock_nxt;
      end
   end
endmodule

// File: tb/tb_axi_addr_arbiter.sv
// tb_axi_addr_arbiter: randomized self-checking bench for axi_addr_arbiter
//
// Two instances share clock and reset: A uses default parameters (4 requesters,
// 64-bit payload), B uses 3 requesters and 16-bit payload to cover wrap on a
// non-power-of-2 count. Honors AXI_ARB_QOS_EN in its reference model.
module tb_axi_addr_arbiter;
   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   logic [3:0]   va, rda;
   logic [15:0]  ida, qa;
   logic [255:0] pa;
   logic         gra, gva;
   logic [5:0]   gida;
   logic [63:0]  gpa;
   logic [3:0]   gqa;
   logic [1:0]   gxa;

   logic [2:0]   vb, rdb;
   logic [11:0]  idb, qb;
   logic [47:0]  pb;
   logic         grb, gvb;
   logic [5:0]   gidb;
   logic [15:0]  gpb;
   logic [3:0]   gqb;
   logic [1:0]   gxb;

   axi_addr_arbiter dut_a (
      .clk(clk), .rstn(rstn), .req_valid(va), .req_ready(rda), .req_id(ida), .req_qos(qa),
      .req_payload(pa), .grant_valid(gva), .grant_ready(gra), .grant_id(gida),
      .grant_payload(gpa), .grant_qos(gqa), .grant_idx(gxa)
   );

   axi_addr_arbiter #(.NUM_MASTER(3), .ID_WIDTH(4), .PAYLOAD_WIDTH(16)) dut_b (
      .clk(clk), .rstn(rstn), .req_valid(vb), .req_ready(rdb), .req_id(idb), .req_qos(qb),
      .req_payload(pb), .grant_valid(gvb), .grant_ready(grb), .grant_id(gidb),
      .grant_payload(gpb), .grant_qos(gqb), .grant_idx(gxb)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state per instance: round-robin start, lock flag, locked requester.
   int m_ptr[2];
   bit m_lk[2];
   int m_li[2];

   logic [3:0]  hs_a, hs_b;
   logic [1:0]  last_gxa, last_gxb;
   logic [63:0] last_gpa;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   function automatic int pick(input int n, input int ptr, input logic [3:0] v, input logic [15:0] q);
      int w    = -1;
      int best = -1;
      for (int i = 0; i < n; i++) begin
         int j = (ptr + i) % n;
`ifdef AXI_ARB_QOS_EN
         if (v[j] && int'(q[j*4 +: 4]) > best) begin
            best = int'(q[j*4 +: 4]);
            w    = j;
         end
`else
         if (v[j] && w < 0) w = j;
`endif
      end
      return w;
   endfunction

   task automatic ref_step(input int k, input int n, input logic [3:0] v, input logic [15:0] q,
                           input logic gr, output int w, output bit gv);
      w  = m_lk[k] ? m_li[k] : pick(n, m_ptr[k], v, q);
      gv = m_lk[k] ? bit'(v[w]) : (w >= 0);
      if (gv && gr) begin
         m_ptr[k] = (w + 1) % n;
         m_lk[k]  = 1'b0;
      end else if (gv) begin
         m_lk[k] = 1'b1;
         m_li[k] = w;
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_ptr[k] = 0;
         m_lk[k]  = 1'b0;
         m_li[k]  = 0;
      end
   endtask

   // Check both instances mid-cycle, advance the model, and return just after the next edge.
   task automatic step();
      int w;
      bit gv;
      logic [3:0] e;
      @(negedge clk);
      ref_step(0, 4, va, qa, gra, w, gv);
      e = (gv && gra) ? 4'(1 << w) : 4'b0;
      chk("a_valid", 64'(gva), 64'(gv));
      chk("a_ready", 64'(rda), 64'(e));
      hs_a = e;
      if (gv) begin
         chk("a_idx", 64'(gxa), 64'(w));
         chk("a_id", 64'(gida), 64'({w[1:0], ida[w*4 +: 4]}));
         chk("a_payload", gpa, pa[w*64 +: 64]);
         chk("a_qos", 64'(gqa), 64'(qa[w*4 +: 4]));
      end
      last_gxa = gxa;
      last_gpa = gpa;
      ref_step(1, 3, {1'b0, vb}, {4'b0, qb}, grb, w, gv);
      e = (gv && grb) ? 4'(1 << w) : 4'b0;
      chk("b_valid", 64'(gvb), 64'(gv));
      chk("b_ready", 64'(rdb), 64'(e[2:0]));
      hs_b = e;
      if (gv) begin
         chk("b_idx", 64'(gxb), 64'(w));
         chk("b_id", 64'(gidb), 64'({w[1:0], idb[w*4 +: 4]}));
         chk("b_payload", 64'(gpb), 64'(pb[w*16 +: 16]));
         chk("b_qos", 64'(gqb), 64'(qb[w*4 +: 4]));
      end
      last_gxb = gxb;
      @(posedge clk);
      #1;
   endtask

   // Requesters keep valid and payload until handshake, except for rare protocol-violating drops.
   task automatic new_inputs();
      for (int i = 0; i < 4; i++) begin
         if (!(va[i] && !hs_a[i] && $urandom_range(19) != 0)) begin
            va[i]          = ($urandom_range(2) != 0);
            ida[i*4 +: 4]  = 4'($urandom);
            qa[i*4 +: 4]   = 4'($urandom_range(3));
            pa[i*64 +: 64] = {$urandom, $urandom};
         end
      end
      for (int i = 0; i < 3; i++) begin
         if (!(vb[i] && !hs_b[i] && $urandom_range(19) != 0)) begin
            vb[i]          = ($urandom_range(2) != 0);
            idb[i*4 +: 4]  = 4'($urandom);
            qb[i*4 +: 4]   = 4'($urandom_range(3));
            pb[i*16 +: 16] = 16'($urandom);
         end
      end
      gra = ($urandom_range(9) < 7);
      grb = ($urandom_range(9) < 7);
   endtask

   initial begin
      logic [63:0] held;
      rstn = 1'b0;
      va = '0; vb = '0; gra = 1'b0; grb = 1'b0;
      ida = 16'hB7E3; idb = 12'h5A1;
      qa = '0; qb = '0;
      pa = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pb = {16'hC0DE, 16'hBEEF, 16'hF00D};
      hs_a = '0; hs_b = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_a_valid", 64'(gva), 64'(0));
      chk("rst_a_ready", 64'(rda), 64'(0));
      chk("rst_b_valid", 64'(gvb), 64'(0));
      va = 4'hF; vb = 3'h7; gra = 1'b1; grb = 1'b1;
      #1;
      chk("rst_a_valid_req", 64'(gva), 64'(0));
      chk("rst_a_ready_req", 64'(rda), 64'(0));
      chk("rst_b_ready_req", 64'(rdb), 64'(0));
      va = '0; vb = '0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      // All four requesting with ready held high: back-to-back grants in rotation.
      va = 4'hF; gra = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("rr_seq", 64'(last_gxa), 64'(i % 4));
      end
      // Back-pressure: grant holds on requester 1 even when requester 3 joins.
      va = 4'b0110; gra = 1'b0;
      held = pa[64 +: 64];
      for (int i = 0; i < 3; i++) begin
         step();
         chk("lock_idx", 64'(last_gxa), 64'(1));
         chk("lock_payload", last_gpa, held);
         va[3] = 1'b1;
      end
      gra = 1'b1;
      step();
      chk("lock_release", 64'(last_gxa), 64'(1));
      va = 4'b0110;
      step();
      chk("after_lock", 64'(last_gxa), 64'(2));
      va = '0;
      // Three requesters: move the pointer to 2, then wrap to 0 and continue to 1.
      vb = 3'b010; grb = 1'b1;
      step();
      chk("b_to_ptr2", 64'(last_gxb), 64'(1));
      vb = 3'b011;
      step();
      chk("b_wrap", 64'(last_gxb), 64'(0));
      step();
      chk("b_next", 64'(last_gxb), 64'(1));
      vb = '0;
      // Reset while locked on requester 2: valid drops immediately, arbitration restarts at 0.
      va = 4'b0100; gra = 1'b0;
      step();
      chk("pre_rst_idx", 64'(last_gxa), 64'(2));
      rstn = 1'b0;
      #1;
      chk("rst_async_valid", 64'(gva), 64'(0));
      chk("rst_async_ready", 64'(rda), 64'(0));
      model_reset();
      @(posedge clk);
      #1;
      rstn = 1'b1;
      va = 4'hF; gra = 1'b1;
      step();
      chk("rst_restart", 64'(last_gxa), 64'(0));
      va = '0;
      hs_a = '0; hs_b = '0;
      for (int c = 0; c < 3000; c++) begin
         new_inputs();
         step();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
